// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bcd_pkg
//  Description : Shared definitions for the sequential binary-to-BCD converter.
//                Holds the FSM state encoding, the BCD digit width, the
//                add-3 threshold and a helper that sizes the bit counter.
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int BCD_DIGIT_W = 4;
   localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

   // The counter must be able to hold the value bin_w itself.
   function automatic int cnt_width(input int bin_w);
      return (bin_w < 1) ? 1 : $clog2(bin_w + 1);
   endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adj
//  Description : Combinational double-dabble digit correction. A digit of
//                five or more gets three added (4-bit, no carry out) so that
//                the following left shift produces a correct decimal carry.
//  Ports       : din  - working BCD digit before the shift
//                dout - adjusted digit
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] din,
   output logic [BCD_DIGIT_W-1:0] dout
);

   assign dout = (din >= ADD3_THRESH) ? (din + 4'd3) : din;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/binary_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : binary_to_bcd_seq
//  Description : Sequential binary to packed-BCD converter using shift-and-
//                add-3, one input bit per clock, behind a start/done
//                handshake. Values of 10**DIGITS or more raise ovf and leave
//                the low DIGITS digits in bcd.
//  Ports       : clk   - rising-edge clock
//                rst_n - synchronous active-low reset
//                start - conversion request, honoured only while not busy
//                bin   - unsigned operand, captured on the accepting edge
//                busy  - conversion in progress
//                done  - one-cycle pulse, bcd/ovf freshly updated
//                bcd   - packed BCD result, digit 0 (units) in bits [3:0]
//                ovf   - result did not fit in DIGITS digits
//  Revision    : 1.0  initial release
// ============================================================================
module binary_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [BIN_W-1:0]              bin,
   output logic                          busy,
   output logic                          done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic                          ovf
);

   localparam int CNT_W = cnt_width(BIN_W);
   localparam int BCD_W = BCD_DIGIT_W * DIGITS;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [BIN_W-1:0] bin_sr;
   logic [BCD_W-1:0] digits;
   logic             ovf_acc;

   logic [BCD_W-1:0] digits_adj;
   logic [BCD_W-1:0] digits_next;
   logic             carry_out;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_adj
         bcd_digit_adj u_adj (
            .din  (digits    [i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (digits_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
         );
      end
   endgenerate

   // Shift the adjusted digits left, pulling the operand MSB into the units
   // LSB; whatever falls off the top digit means the value no longer fits.
   assign carry_out   = digits_adj[BCD_W-1];
   assign digits_next = {digits_adj[BCD_W-2:0], bin_sr[BIN_W-1]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bin_sr  <= '0;
         digits  <= '0;
         ovf_acc <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd     <= '0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  bin_sr  <= bin;
                  digits  <= '0;
                  ovf_acc <= 1'b0;
                  cnt     <= CNT_W'(BIN_W);
                  busy    <= 1'b1;
                  state   <= ST_SHIFT;
               end else begin
                  state   <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               digits  <= digits_next;
               bin_sr  <= bin_sr << 1;
               ovf_acc <= ovf_acc | carry_out;
               cnt     <= cnt - 1'b1;
               // Counter at one means this edge performs the final shift.
               if (cnt == CNT_W'(1)) begin
                  bcd   <= digits_next;
                  ovf   <= ovf_acc | carry_out;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule : binary_to_bcd_seq
`default_nettype wire
